set_assoc_dcache_ctrl: RTL and testbench
========================================

Name: set_assoc_dcache_ctrl

Overview:
Parametrised set-associative data-cache controller. It tracks tags, valid, dirty and true-LRU state for a trace-driven cache model, and uses the trace command encoding.
Multi-cycle FSM with a valid/ready command interface and a valid/ready next-level memory port. Supports write-back/write-allocate or write-through/no-allocate.
Maintains saturating hit, miss, read and write statistics.

Parameters:
ADDR_W, 32, byte address width
OFFSET_W, 6, line offset bits (64 B line)
INDEX_W, 14, set index bits (16K sets)
WAYS, 4, associativity, power of two, >= 2
WRITE_BACK, 1, 1 = write-back/write-allocate, 0 = write-through/no-allocate
CNT_W, 32, statistics counter width
Derived: TAG_W = ADDR_W-OFFSET_W-INDEX_W; LINE_W = ADDR_W-OFFSET_W; AGE_W = clog2(WAYS)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller idle, can accept
cmd_op  in  4  0 READ, 1 WRITE, 3 INVALIDATE, 8 CLEAR; others = no-op
cmd_addr  in  ADDR_W  byte address
rsp_valid  out  1  one-cycle completion pulse
rsp_hit  out  1  tag hit on a valid line, qualified by rsp_valid
mem_valid  out  1  next-level request
mem_ready  in  1  next-level accept
mem_write  out  1  1 = line write (eviction/write-through), 0 = line fill
mem_addr  out  LINE_W  line address
hit_cnt, miss_cnt, read_cnt, write_cnt  out  CNT_W each  statistics

Behaviour:
- Reset (async, immediate): state IDLE; cmd_ready=1; rsp_valid=0; rsp_hit=0; mem_valid=0; mem_write=0; mem_addr=0; all counters 0; all valid/dirty bits 0; ages[s][w]=w.
- Tags are not reset. Reset mid-transaction aborts it: no array update, no response.
- States: IDLE, LOOKUP, EVICT, FILL, WTHRU, RESP, CLEAR.
- IDLE: cmd_ready=1 only here. Accept on cmd_valid&&cmd_ready; latch op and addr.
  - At accept: READ increments read_cnt, WRITE increments write_cnt.
  - CLEAR zeroes all four counters and goes to CLEAR.
  - Unknown op goes to RESP with rsp_hit=0.
  - READ, WRITE and INVALIDATE go to LOOKUP.
- LOOKUP (one cycle): compare all ways in parallel.
  - READ/WRITE: hit increments hit_cnt, miss increments miss_cnt.
  - Hit: victim/target = hit way.
  - Read or write-allocate miss: victim = lowest-index invalid way, else the way with age WAYS-1.
- Transitions out of LOOKUP:
  - READ hit: touch LRU, go RESP. Hit latency: rsp_valid is high 2 cycles after the accept edge.
  - WRITE hit, WRITE_BACK=1: set dirty, touch LRU, go RESP.
  - WRITE hit, WRITE_BACK=0: touch LRU, go WTHRU.
  - READ miss, or WRITE miss with WRITE_BACK=1: go EVICT if the victim is valid and dirty, else FILL.
  - WRITE miss, WRITE_BACK=0: go WTHRU; no allocate, LRU untouched.
  - INVALIDATE hit: if dirty, go EVICT then RESP; otherwise clear valid/dirty and go RESP. Ages are unchanged.
  - INVALIDATE miss: go RESP with rsp_hit=0.
- EVICT: mem_valid=1, mem_write=1, mem_addr={victim tag, index}, held stable until mem_ready. Then go FILL (read/write) or RESP (invalidate, clearing valid/dirty).
- FILL: mem_valid=1, mem_write=0, mem_addr=cmd line, held until mem_ready. Then write tag, valid=1, dirty=(op==WRITE), touch LRU, go RESP.
- WTHRU: mem_valid=1, mem_write=1, mem_addr=cmd line, held until mem_ready, then RESP.
- mem_ready while mem_valid=0 is ignored.
- RESP: rsp_valid=1 for exactly one cycle, rsp_hit from LOOKUP, then IDLE.
- CLEAR: one set per cycle, index 0 to 2^INDEX_W-1. Valid=dirty=0, ages reset; dirty lines are discarded without writeback. After the last set go RESP (rsp_hit=0).
- LRU touch of way w with old age a: ways with age < a increment, w becomes 0. Ages always remain a permutation of 0..WAYS-1.
- Counters saturate at 2^CNT_W-1; no wrap.
- Duplicate tags within a set cannot arise (fills only on miss).

Decomposition:
- Package dcache_pkg holds:
  - op encodings (READ=0, WRITE=1, INVALIDATE=3, CLEAR=8);
  - state enum;
  - clog2 and TAG_W/LINE_W derivation functions.
- Sub-module cache_lru_age (WAYS param), combinational:
  - inputs: set age vector, touched way, valid vector;
  - outputs: updated age vector, victim way.

Test Plan:
1. rst; READ 0x00000040 -> miss, FILL mem_addr=0x0000001, mem_ready after 3 cycles, rsp_hit=0. Repeat READ -> rsp_valid 2 cycles after accept, rsp_hit=1. Counters hit=1, miss=1, read=2.
2. WRITE 0x00100000, 0x00200000, 0x00300000, 0x00400000 (set 0), READ 0x00100000, READ 0x00500000 -> EVICT mem_write=1 mem_addr=0x08000, then FILL mem_addr=0x14000.
3. WRITE_BACK=0: WRITE 0x00001000 -> WTHRU mem_write=1 mem_addr=0x40, no allocate. READ 0x00001000 -> miss plus FILL 0x40.
4. INVALIDATE a dirty line -> EVICT then rsp_hit=1; a later READ misses. INVALIDATE an absent address -> rsp_hit=0, mem_valid never asserted.
5. INDEX_W=4: after fills, CLEAR -> cmd_ready low ~17 cycles, counters 0, no mem traffic; subsequent READs all miss.
6. rst pulsed while FILL mem_valid=1 -> mem_valid=0 immediately, cmd_ready=1. CNT_W=4 with 17 READs -> read_cnt=15.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared command encodings, FSM state codes and width helpers for the
// set-associative data-cache controller.
package dcache_pkg;

    localparam logic [3:0] OP_READ       = 4'd0;
    localparam logic [3:0] OP_WRITE      = 4'd1;
    localparam logic [3:0] OP_INVALIDATE = 4'd3;
    localparam logic [3:0] OP_CLEAR      = 4'd8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOOKUP = 3'd1;
    localparam state_t ST_EVICT  = 3'd2;
    localparam state_t ST_FILL   = 3'd3;
    localparam state_t ST_WTHRU  = 3'd4;
    localparam state_t ST_RESP   = 3'd5;
    localparam state_t ST_CLEAR  = 3'd6;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int tag_width(input int addr_w, input int offset_w, input int index_w);
        return addr_w - offset_w - index_w;
    endfunction

    function automatic int line_width(input int addr_w, input int offset_w);
        return addr_w - offset_w;
    endfunction

endpackage

// File: rtl/cache_lru_age.sv
// True-LRU age update and victim choice for one set; purely combinational.
module cache_lru_age
    import dcache_pkg::*;
#(
    parameter  int WAYS  = 4,
    localparam int AGE_W = clog2(WAYS)
) (
    input  logic [WAYS-1:0][AGE_W-1:0] ages_in,
    input  logic [AGE_W-1:0]           touch_way,
    input  logic [WAYS-1:0]            valid,
    output logic [WAYS-1:0][AGE_W-1:0] ages_out,
    output logic [AGE_W-1:0]           victim
);

    logic [AGE_W-1:0] touch_age;
    logic             found;

    assign touch_age = ages_in[touch_way];

    always_comb begin
        // NOTE: defaults come first so every path assigns every output and no latch is inferred.
        ages_out = ages_in;
        for (int w = 0; w < WAYS; w++) begin
            if (ages_in[w] < touch_age) ages_out[w] = ages_in[w] + AGE_W'(1);
        end
        ages_out[touch_way] = '0;
    end

    // Prefer an empty way; otherwise evict the oldest line.
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid[w]) begin
                victim = AGE_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ages_in[w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
            end
        end
    end

endmodule

// File: rtl/set_assoc_dcache_ctrl.sv
// Set-associative data-cache controller: tag/valid/dirty/LRU bookkeeping,
// next-level line traffic and saturating statistics for a trace-driven model.
module set_assoc_dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int OFFSET_W   = 6,
    parameter int INDEX_W    = 14,
    parameter int WAYS       = 4,
    parameter int WRITE_BACK = 1,
    parameter int CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_op,
    input  logic [ADDR_W-1:0]          cmd_addr,
    output logic                       rsp_valid,
    output logic                       rsp_hit,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic                       mem_write,
    output logic [ADDR_W-OFFSET_W-1:0] mem_addr,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic [CNT_W-1:0]           miss_cnt,
    output logic [CNT_W-1:0]           read_cnt,
    output logic [CNT_W-1:0]           write_cnt
);

    localparam int   TAG_W  = tag_width(ADDR_W, OFFSET_W, INDEX_W);
    localparam int   LINE_W = line_width(ADDR_W, OFFSET_W);
    localparam int   AGE_W  = clog2(WAYS);
    localparam int   SETS   = 1 << INDEX_W;
    localparam logic WB     = (WRITE_BACK != 0);

    typedef logic [WAYS-1:0][AGE_W-1:0] age_vec_t;

    function automatic age_vec_t age_reset();
        age_vec_t a;
        for (int w = 0; w < WAYS; w++) a[w] = AGE_W'(w);
        return a;
    endfunction

    localparam age_vec_t AGE_INIT = age_reset();

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t              state;
    logic [3:0]          op_q;
    logic [LINE_W-1:0]   line_q;
    logic                hit_q;
    logic [AGE_W-1:0]    way_q;
    logic [TAG_W-1:0]    vtag_q;
    logic [INDEX_W-1:0]  clr_idx;

    logic [WAYS-1:0]     valid_r [SETS];
    logic [WAYS-1:0]     dirty_r [SETS];
    age_vec_t            age_r   [SETS];
    logic [TAG_W-1:0]    tag_r   [SETS][WAYS];

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic [AGE_W-1:0]    hit_way;
    logic [AGE_W-1:0]    victim;
    logic [AGE_W-1:0]    tgt_way;
    age_vec_t            age_next;
    logic                victim_dirty;
    logic                hit_dirty;
    logic                do_touch;
    logic                do_fill;
    logic                do_dirty;
    logic                do_inval;

    assign idx = line_q[INDEX_W-1:0];
    assign tag = line_q[LINE_W-1:INDEX_W];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_r[idx][w] && (tag_r[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // During LOOKUP the target is chosen live; afterwards it is the latched way.
    assign tgt_way      = (state == ST_LOOKUP) ? (hit ? hit_way : victim) : way_q;
    assign victim_dirty = valid_r[idx][victim] && dirty_r[idx][victim];
    assign hit_dirty    = dirty_r[idx][hit_way];

    cache_lru_age #(.WAYS(WAYS)) u_lru (
        .ages_in   (age_r[idx]),
        .touch_way (tgt_way),
        .valid     (valid_r[idx]),
        .ages_out  (age_next),
        .victim    (victim)
    );

    assign do_fill  = (state == ST_FILL) && mem_ready;
    assign do_touch = do_fill ||
                      ((state == ST_LOOKUP) && hit && ((op_q == OP_READ) || (op_q == OP_WRITE)));
    assign do_dirty = (state == ST_LOOKUP) && hit && (op_q == OP_WRITE) && WB;
    assign do_inval = ((state == ST_LOOKUP) && hit && (op_q == OP_INVALIDATE) && !hit_dirty) ||
                      ((state == ST_EVICT) && mem_ready && (op_q == OP_INVALIDATE));

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_hit   = rsp_valid && hit_q;
    assign mem_valid = (state == ST_EVICT) || (state == ST_FILL) || (state == ST_WTHRU);
    assign mem_write = (state == ST_EVICT) || (state == ST_WTHRU);

    always_comb begin
        mem_addr = '0;
        if (state == ST_EVICT)                             mem_addr = {vtag_q, idx};
        else if ((state == ST_FILL) || (state == ST_WTHRU)) mem_addr = line_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            line_q    <= '0;
            hit_q     <= 1'b0;
            way_q     <= '0;
            vtag_q    <= '0;
            clr_idx   <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            read_cnt  <= '0;
            write_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        line_q <= cmd_addr[ADDR_W-1:OFFSET_W];
                        hit_q  <= 1'b0;
                        case (cmd_op)
                            OP_READ: begin
                                read_cnt <= sat_inc(read_cnt);
                                state    <= ST_LOOKUP;
                            end
                            OP_WRITE: begin
                                write_cnt <= sat_inc(write_cnt);
                                state     <= ST_LOOKUP;
                            end
                            OP_INVALIDATE: state <= ST_LOOKUP;
                            OP_CLEAR: begin
                                hit_cnt   <= '0;
                                miss_cnt  <= '0;
                                read_cnt  <= '0;
                                write_cnt <= '0;
                                clr_idx   <= '0;
                                state     <= ST_CLEAR;
                            end
                            default: state <= ST_RESP;
                        endcase
                    end
                end
                ST_LOOKUP: begin
                    hit_q  <= hit;
                    way_q  <= tgt_way;
                    vtag_q <= tag_r[idx][tgt_way];
                    if ((op_q == OP_READ) || (op_q == OP_WRITE)) begin
                        if (hit) hit_cnt  <= sat_inc(hit_cnt);
                        else     miss_cnt <= sat_inc(miss_cnt);
                    end
                    if (op_q == OP_INVALIDATE)
                        state <= (hit && hit_dirty) ? ST_EVICT : ST_RESP;
                    else if ((op_q == OP_WRITE) && !WB)
                        state <= ST_WTHRU;
                    else if (hit)
                        state <= ST_RESP;
                    else
                        state <= victim_dirty ? ST_EVICT : ST_FILL;
                end
                ST_EVICT: if (mem_ready) state <= (op_q == OP_INVALIDATE) ? ST_RESP : ST_FILL;
                ST_FILL:  if (mem_ready) state <= ST_RESP;
                ST_WTHRU: if (mem_ready) state <= ST_RESP;
                ST_CLEAR: begin
                    if (clr_idx == '1) begin
                        hit_q <= 1'b0;
                        state <= ST_RESP;
                    end else begin
                        clr_idx <= clr_idx + INDEX_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                age_r[s]   <= AGE_INIT;
            end
        end else begin
            if (state == ST_CLEAR) begin
                valid_r[clr_idx] <= '0;
                dirty_r[clr_idx] <= '0;
                age_r[clr_idx]   <= AGE_INIT;
            end
            if (do_touch) age_r[idx] <= age_next;
            if (do_fill) begin
                valid_r[idx][tgt_way] <= 1'b1;
                dirty_r[idx][tgt_way] <= (op_q == OP_WRITE);
            end
            if (do_dirty) dirty_r[idx][tgt_way] <= 1'b1;
            if (do_inval) begin
                valid_r[idx][tgt_way] <= 1'b0;
                dirty_r[idx][tgt_way] <= 1'b0;
            end
        end
    end

    // NOTE: tag storage is deliberately not reset; a tag is only ever read under its valid bit.
    always_ff @(posedge clk) begin
        if (do_fill) tag_r[idx][way_q] <= tag;
    end

endmodule

// File: tb/tb_set_assoc_dcache_ctrl.sv
// Directed bench: three controller instances (write-back 16K sets, write-through
// 16 sets, write-back 16 sets with 4-bit counters) driven by one linear sequence.
module tb_set_assoc_dcache_ctrl;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        cmd_valid [3];
    logic        cmd_ready [3];
    logic [3:0]  cmd_op    [3];
    logic [31:0] cmd_addr  [3];
    logic        rsp_valid [3];
    logic        rsp_hit   [3];
    logic        mem_valid [3];
    logic        mem_ready [3];
    logic        mem_write [3];
    logic [25:0] mem_addr  [3];

    logic [31:0] hc0, mc0, rc0, wc0;
    logic [31:0] hc1, mc1, rc1, wc1;
    logic [3:0]  hc2, mc2, rc2, wc2;

    int          checks   = 0;
    int          failures = 0;

    int          mem_n;
    logic        mem_w0, mem_w1;
    logic [25:0] mem_a0, mem_a1;
    logic        rsp_h;
    int          rsp_lat;
    logic        post_idle;

    always #5 clk = ~clk;

    set_assoc_dcache_ctrl #(.INDEX_W(14), .WRITE_BACK(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_addr(cmd_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_hit(rsp_hit[0]),
        .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]), .mem_write(mem_write[0]),
        .mem_addr(mem_addr[0]), .hit_cnt(hc0), .miss_cnt(mc0), .read_cnt(rc0), .write_cnt(wc0)
    );

    set_assoc_dcache_ctrl #(.INDEX_W(4), .WRITE_BACK(0), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_addr(cmd_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_hit(rsp_hit[1]),
        .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]), .mem_write(mem_write[1]),
        .mem_addr(mem_addr[1]), .hit_cnt(hc1), .miss_cnt(mc1), .read_cnt(rc1), .write_cnt(wc1)
    );

    set_assoc_dcache_ctrl #(.INDEX_W(4), .WRITE_BACK(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_op(cmd_op[2]), .cmd_addr(cmd_addr[2]), .rsp_valid(rsp_valid[2]), .rsp_hit(rsp_hit[2]),
        .mem_valid(mem_valid[2]), .mem_ready(mem_ready[2]), .mem_write(mem_write[2]),
        .mem_addr(mem_addr[2]), .hit_cnt(hc2), .miss_cnt(mc2), .read_cnt(rc2), .write_cnt(wc2)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one command, answers up to two memory requests after `lat` cycles,
    // and records the requests, the response and its latency from accept.
    task automatic run_cmd(input int d, input logic [3:0] op, input logic [31:0] addr, input int lat);
        int cyc;
        int wait_n;
        bit done;
        mem_n = 0; mem_w0 = 1'b0; mem_w1 = 1'b0; mem_a0 = '0; mem_a1 = '0;
        rsp_h = 1'b0; rsp_lat = -1; post_idle = 1'b0;
        cmd_valid[d] = 1'b1;
        cmd_op[d]    = op;
        cmd_addr[d]  = addr;
        @(posedge clk); #1;
        cmd_valid[d] = 1'b0;
        cyc = 1; wait_n = 0; done = 1'b0;
        while (!done && cyc < 300) begin
            if (mem_ready[d]) begin
                mem_ready[d] = 1'b0;
                wait_n = 0;
            end
            if (rsp_valid[d]) begin
                rsp_h   = rsp_hit[d];
                rsp_lat = cyc;
                done    = 1'b1;
            end else begin
                if (mem_valid[d]) begin
                    if (wait_n == 0) begin
                        if (mem_n == 0) begin mem_w0 = mem_write[d]; mem_a0 = mem_addr[d]; end
                        else if (mem_n == 1) begin mem_w1 = mem_write[d]; mem_a1 = mem_addr[d]; end
                        mem_n++;
                    end
                    wait_n++;
                    if (wait_n >= lat) mem_ready[d] = 1'b1;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (done) begin
            @(posedge clk); #1;
            post_idle = cmd_ready[d] && !rsp_valid[d];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        for (int d = 0; d < 3; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_op[d]    = 4'd0;
            cmd_addr[d]  = '0;
            mem_ready[d] = 1'b0;
        end

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_cmd_ready", cmd_ready[0], 1);
        check("rst_rsp_valid", rsp_valid[0], 0);
        check("rst_rsp_hit",   rsp_hit[0],   0);
        check("rst_mem_valid", mem_valid[0], 0);
        check("rst_mem_write", mem_write[0], 0);
        check("rst_mem_addr",  mem_addr[0],  0);
        check("rst_counters",  {hc0[7:0], mc0[7:0], rc0[7:0], wc0[7:0]}, 0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // 1: read miss then read hit
        run_cmd(0, OP_READ, 32'h0000_0040, 3);
        check("t1_miss_hit",   rsp_h,  0);
        check("t1_miss_nreq",  mem_n,  1);
        check("t1_fill_write", mem_w0, 0);
        check("t1_fill_addr",  mem_a0, 26'h1);
        check("t1_miss_lat",   rsp_lat, 5);
        check("t1_post_idle",  post_idle, 1);
        run_cmd(0, OP_READ, 32'h0000_0040, 3);
        check("t1_hit",        rsp_h,  1);
        check("t1_hit_lat",    rsp_lat, 2);
        check("t1_hit_nreq",   mem_n,  0);
        check("t1_hit_cnt",    hc0, 1);
        check("t1_miss_cnt",   mc0, 1);
        check("t1_read_cnt",   rc0, 2);

        // 2: fill set 0, touch way 0, dirty LRU victim is way 1 (tag 2)
        run_cmd(0, OP_WRITE, 32'h0010_0000, 2);
        run_cmd(0, OP_WRITE, 32'h0020_0000, 2);
        run_cmd(0, OP_WRITE, 32'h0030_0000, 2);
        run_cmd(0, OP_WRITE, 32'h0040_0000, 2);
        check("t2_wmiss_fill", {mem_n[3:0], 3'd0, mem_w0}, {4'd1, 3'd0, 1'b0});
        run_cmd(0, OP_READ, 32'h0010_0000, 2);
        check("t2_read_hit",   rsp_h, 1);
        run_cmd(0, OP_READ, 32'h0050_0000, 2);
        check("t2_nreq",       mem_n,  2);
        check("t2_evict_wr",   mem_w0, 1);
        check("t2_evict_addr", mem_a0, 26'h08000);
        check("t2_fill_wr",    mem_w1, 0);
        check("t2_fill_addr",  mem_a1, 26'h14000);
        check("t2_rsp_hit",    rsp_h,  0);

        // 4: invalidate dirty line, re-read it, invalidate absent line
        run_cmd(0, OP_INVALIDATE, 32'h0030_0000, 2);
        check("t4_inv_nreq",   mem_n,  1);
        check("t4_inv_wr",     mem_w0, 1);
        check("t4_inv_addr",   mem_a0, 26'h0C000);
        check("t4_inv_hit",    rsp_h,  1);
        run_cmd(0, OP_READ, 32'h0030_0000, 2);
        check("t4_reread_hit", rsp_h,  0);
        check("t4_reread_req", {mem_n[3:0], 3'd0, mem_w0, 6'd0, mem_a0}, {4'd1, 3'd0, 1'b0, 6'd0, 26'h0C000});
        run_cmd(0, OP_INVALIDATE, 32'h0060_0000, 2);
        check("t4_absent_hit", rsp_h, 0);
        check("t4_absent_req", mem_n, 0);
        check("t4_counters",   {hc0[7:0], mc0[7:0], rc0[7:0], wc0[7:0]}, {8'd2, 8'd7, 8'd5, 8'd4});

        // 3: write-through / no-allocate, plus an unknown opcode
        run_cmd(1, OP_WRITE, 32'h0000_1000, 2);
        check("t3_wt_nreq",    mem_n,  1);
        check("t3_wt_wr",      mem_w0, 1);
        check("t3_wt_addr",    mem_a0, 26'h40);
        check("t3_wt_hit",     rsp_h,  0);
        run_cmd(1, OP_READ, 32'h0000_1000, 2);
        check("t3_rd_hit",     rsp_h,  0);
        check("t3_rd_req",     {mem_n[3:0], 3'd0, mem_w0, 6'd0, mem_a0}, {4'd1, 3'd0, 1'b0, 6'd0, 26'h40});
        run_cmd(1, OP_WRITE, 32'h0000_1000, 2);
        check("t3_whit_hit",   rsp_h, 1);
        check("t3_whit_req",   {mem_n[3:0], 3'd0, mem_w0, 6'd0, mem_a0}, {4'd1, 3'd0, 1'b1, 6'd0, 26'h40});
        run_cmd(1, 4'd5, 32'h0000_1000, 2);
        check("t3_nop_lat",    rsp_lat, 1);
        check("t3_nop_hit",    rsp_h,   0);
        check("t3_nop_req",    mem_n,   0);
        check("t3_counters",   {hc1[7:0], mc1[7:0], rc1[7:0], wc1[7:0]}, {8'd1, 8'd2, 8'd1, 8'd2});

        // 5: clear with a dirty line present
        run_cmd(2, OP_READ,  32'h0000_0040, 1);
        run_cmd(2, OP_READ,  32'h0000_0080, 1);
        run_cmd(2, OP_WRITE, 32'h0000_0000, 1);
        run_cmd(2, OP_CLEAR, 32'h0000_0000, 1);
        check("t5_clr_lat",    rsp_lat, 17);
        check("t5_clr_hit",    rsp_h,   0);
        check("t5_clr_req",    mem_n,   0);
        check("t5_clr_cnt",    {hc2, mc2, rc2, wc2}, 16'h0000);
        run_cmd(2, OP_READ, 32'h0000_0040, 1);
        check("t5_rd1_hit",    rsp_h, 0);
        check("t5_rd1_req",    {mem_n[3:0], 3'd0, mem_w0, 6'd0, mem_a0}, {4'd1, 3'd0, 1'b0, 6'd0, 26'h1});
        run_cmd(2, OP_READ, 32'h0000_0000, 1);
        check("t5_rd0_hit",    rsp_h, 0);
        check("t5_rd0_req",    {mem_n[3:0], 3'd0, mem_w0, 6'd0, mem_a0}, {4'd1, 3'd0, 1'b0, 6'd0, 26'h0});

        // 6: counter saturation at 15
        for (int i = 0; i < 17; i++) run_cmd(2, OP_READ, 32'h0000_0000, 1);
        check("t6_last_hit",   rsp_h, 1);
        check("t6_read_sat",   rc2, 4'd15);
        check("t6_hit_sat",    hc2, 4'd15);
        check("t6_miss_cnt",   mc2, 4'd2);

        // 6: reset while a fill is outstanding
        cmd_valid[2] = 1'b1;
        cmd_op[2]    = OP_READ;
        cmd_addr[2]  = 32'h0000_1000;
        @(posedge clk); #1;
        cmd_valid[2] = 1'b0;
        n = 0;
        while (!mem_valid[2] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_fill_pending", {mem_valid[2], mem_write[2]}, 2'b10);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_mem_valid", mem_valid[2], 0);
        check("t6_rst_cmd_ready", cmd_ready[2], 1);
        check("t6_rst_mem_addr",  mem_addr[2],  0);
        check("t6_rst_read_cnt",  rc2, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("t6_no_rsp", rsp_valid[2], 0);
        run_cmd(2, OP_READ, 32'h0000_0000, 1);
        check("t6_after_rst_hit", rsp_h, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
